// File: rtl/id_ex_operand_stage_if.sv
// ID/EX operand-stage bus: decoded ID fields, forwarding sources, EX-side ALU operands.
// Ports: i_* are ID/forwarding inputs to the stage, o_* are ALU operands and write-back control.
// Modports: master drives the i_* side (ID stage / bench), slave is the operand stage itself.
interface id_ex_operand_stage_if #(
  parameter int N_BITS   = 32,
  parameter int N_OPCODE = 6,
  parameter int N_REG    = 5
);
  logic                i_valid;
  logic [5:0]          i_op;
  logic [5:0]          i_funct;
  logic [4:0]          i_shamt;
  logic [15:0]         i_imm;
  logic [N_REG-1:0]    i_rs_addr;
  logic [N_REG-1:0]    i_rt_addr;
  logic [N_REG-1:0]    i_rd_addr;
  logic [N_BITS-1:0]   i_rs_data;
  logic [N_BITS-1:0]   i_rt_data;
  logic                i_stall;
  logic                i_flush;
  logic                i_exmem_regwrite;
  logic [N_REG-1:0]    i_exmem_rd;
  logic [N_BITS-1:0]   i_exmem_result;
  logic                i_memwb_regwrite;
  logic [N_REG-1:0]    i_memwb_rd;
  logic [N_BITS-1:0]   i_memwb_result;
  logic [N_BITS-1:0]   o_datoA;
  logic [N_BITS-1:0]   o_datoB;
  logic [N_OPCODE-1:0] o_alu_opcode;
  logic                o_valid;
  logic                o_regwrite;
  logic [N_REG-1:0]    o_wb_rd;
  logic                o_illegal;

  modport master (
    output i_valid, i_op, i_funct, i_shamt, i_imm, i_rs_addr, i_rt_addr, i_rd_addr,
           i_rs_data, i_rt_data, i_stall, i_flush,
           i_exmem_regwrite, i_exmem_rd, i_exmem_result,
           i_memwb_regwrite, i_memwb_rd, i_memwb_result,
    input  o_datoA, o_datoB, o_alu_opcode, o_valid, o_regwrite, o_wb_rd, o_illegal
  );

  modport slave (
    input  i_valid, i_op, i_funct, i_shamt, i_imm, i_rs_addr, i_rt_addr, i_rd_addr,
           i_rs_data, i_rt_data, i_stall, i_flush,
           i_exmem_regwrite, i_exmem_rd, i_exmem_result,
           i_memwb_regwrite, i_memwb_rd, i_memwb_result,
    output o_datoA, o_datoB, o_alu_opcode, o_valid, o_regwrite, o_wb_rd, o_illegal
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX register + ALU operand select: decodes op/funct to an ALU code and picks A/B operands.
// Latency 1 cycle ID->EX; forwarding is combinational on the latched rs/rt (macro ID_EX_FORWARD_EN).
// Backpressure: i_stall holds every register, i_flush (wins over stall) loads a bubble.
// Ports: i_clk, i_rst_n (async active-low) plus the slave side of id_ex_operand_stage_if.
module id_ex_operand_stage #(
  parameter int N_BITS   = 32,
  parameter int N_OPCODE = 6,
  parameter int N_REG    = 5
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  id_ex_operand_stage_if.slave   bus
);

  localparam logic [N_OPCODE-1:0] ALU_AND  = N_OPCODE'(0);
  localparam logic [N_OPCODE-1:0] ALU_OR   = N_OPCODE'(1);
  localparam logic [N_OPCODE-1:0] ALU_ADD  = N_OPCODE'(2);
  localparam logic [N_OPCODE-1:0] ALU_ADDU = N_OPCODE'(3);
  localparam logic [N_OPCODE-1:0] ALU_NOR  = N_OPCODE'(4);
  localparam logic [N_OPCODE-1:0] ALU_XOR  = N_OPCODE'(5);
  localparam logic [N_OPCODE-1:0] ALU_SLL  = N_OPCODE'(6);
  localparam logic [N_OPCODE-1:0] ALU_SRL  = N_OPCODE'(7);
  localparam logic [N_OPCODE-1:0] ALU_SRA  = N_OPCODE'(8);
  localparam logic [N_OPCODE-1:0] ALU_SLLV = N_OPCODE'(9);
  localparam logic [N_OPCODE-1:0] ALU_SRLV = N_OPCODE'(10);
  localparam logic [N_OPCODE-1:0] ALU_SRAV = N_OPCODE'(11);
  localparam logic [N_OPCODE-1:0] ALU_SUBU = N_OPCODE'(12);
  localparam logic [N_OPCODE-1:0] ALU_SUB  = N_OPCODE'(13);
  localparam logic [N_OPCODE-1:0] ALU_SLT  = N_OPCODE'(14);
  // LUI takes the first code after SLT; the ALU shifts B left by 16.
  localparam logic [N_OPCODE-1:0] ALU_LUI  = N_OPCODE'(15);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // Latched stage contents. The all-zero value is the bubble: addresses of 0 never
  // forward, so a bubble also drives zero operands.
  typedef struct packed {
    logic                valid;
    logic                regwrite;
    logic                illegal;
    logic [N_REG-1:0]    wb_rd;
    logic [N_OPCODE-1:0] alu_op;
    logic                a_from_rt;   // shifts by shamt operate on rt
    logic                b_from_imm;  // B comes from imm (extended imm or shamt), never forwarded
    logic [N_BITS-1:0]   imm;
    logic [N_REG-1:0]    rs_addr;
    logic [N_REG-1:0]    rt_addr;
    logic [N_BITS-1:0]   rs_data;
    logic [N_BITS-1:0]   rt_data;
  } stage_t;

  stage_t stage_q, stage_d, cap;
  logic   dec_ok;
  logic   is_shift;

  logic [N_BITS-1:0] imm_sx, imm_zx, shamt_zx;
  assign imm_sx   = {{(N_BITS-16){bus.i_imm[15]}}, bus.i_imm};
  assign imm_zx   = {{(N_BITS-16){1'b0}}, bus.i_imm};
  assign shamt_zx = {{(N_BITS-5){1'b0}}, bus.i_shamt};

  // Decode of the current ID instruction into the value that a capture would latch.
  always_comb begin
    cap          = '0;
    dec_ok       = 1'b1;
    is_shift     = 1'b0;
    cap.valid    = 1'b1;
    cap.rs_addr  = bus.i_rs_addr;
    cap.rt_addr  = bus.i_rt_addr;
    cap.rs_data  = bus.i_rs_data;
    cap.rt_data  = bus.i_rt_data;
    if (bus.i_op == OP_RTYPE) begin
      cap.wb_rd = bus.i_rd_addr;
      case (bus.i_funct)
        6'b100100: cap.alu_op = ALU_AND;
        6'b100101: cap.alu_op = ALU_OR;
        6'b100000: cap.alu_op = ALU_ADD;
        6'b100001: cap.alu_op = ALU_ADDU;
        6'b100111: cap.alu_op = ALU_NOR;
        6'b100110: cap.alu_op = ALU_XOR;
        6'b100011: cap.alu_op = ALU_SUBU;
        6'b100010: cap.alu_op = ALU_SUB;
        6'b101010: cap.alu_op = ALU_SLT;
        6'b000100: cap.alu_op = ALU_SLLV;
        6'b000110: cap.alu_op = ALU_SRLV;
        6'b000111: cap.alu_op = ALU_SRAV;
        6'b000000: begin cap.alu_op = ALU_SLL; is_shift = 1'b1; end
        6'b000010: begin cap.alu_op = ALU_SRL; is_shift = 1'b1; end
        6'b000011: begin cap.alu_op = ALU_SRA; is_shift = 1'b1; end
        default:   dec_ok = 1'b0;
      endcase
      if (is_shift) begin
        cap.a_from_rt  = 1'b1;
        cap.b_from_imm = 1'b1;
        cap.imm        = shamt_zx;
      end
    end else begin
      cap.wb_rd      = bus.i_rt_addr;
      cap.b_from_imm = 1'b1;
      case (bus.i_op)
        OP_ADDI: begin cap.alu_op = ALU_ADD;  cap.imm = imm_sx; end
        OP_SLTI: begin cap.alu_op = ALU_SLT;  cap.imm = imm_sx; end
        OP_ANDI: begin cap.alu_op = ALU_AND;  cap.imm = imm_zx; end
        OP_ORI:  begin cap.alu_op = ALU_OR;   cap.imm = imm_zx; end
        OP_XORI: begin cap.alu_op = ALU_XOR;  cap.imm = imm_zx; end
        OP_LUI:  begin cap.alu_op = ALU_LUI;  cap.imm = imm_zx; end
        OP_LW:   begin cap.alu_op = ALU_ADDU; cap.imm = imm_sx; end
        OP_SW:   begin cap.alu_op = ALU_ADDU; cap.imm = imm_sx; end
        default: dec_ok = 1'b0;
      endcase
    end
    // Writes to $0 are dropped here so the NOP encoding (SLL $0) never writes back.
    cap.regwrite = (cap.wb_rd != '0) && (bus.i_op != OP_SW);
  end

  always_comb begin
    stage_d = stage_q;
    if (bus.i_flush) begin
      stage_d = '0;
    end else if (bus.i_stall) begin
      stage_d = stage_q;
    end else if (!bus.i_valid) begin
      stage_d = '0;
    end else if (!dec_ok) begin
      stage_d         = '0;
      stage_d.illegal = 1'b1;
    end else begin
      stage_d = cap;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  logic [N_BITS-1:0] rs_val, rt_val;

`ifdef ID_EX_FORWARD_EN
  // MEM/WB is applied first so a matching EX/MEM (the younger result) overrides it.
  always_comb begin
    rs_val = stage_q.rs_data;
    rt_val = stage_q.rt_data;
    if (bus.i_memwb_regwrite && (bus.i_memwb_rd != '0) && (bus.i_memwb_rd == stage_q.rs_addr))
      rs_val = bus.i_memwb_result;
    if (bus.i_exmem_regwrite && (bus.i_exmem_rd != '0) && (bus.i_exmem_rd == stage_q.rs_addr))
      rs_val = bus.i_exmem_result;
    if (bus.i_memwb_regwrite && (bus.i_memwb_rd != '0) && (bus.i_memwb_rd == stage_q.rt_addr))
      rt_val = bus.i_memwb_result;
    if (bus.i_exmem_regwrite && (bus.i_exmem_rd != '0) && (bus.i_exmem_rd == stage_q.rt_addr))
      rt_val = bus.i_exmem_result;
  end
`else
  always_comb begin
    rs_val = stage_q.rs_data;
    rt_val = stage_q.rt_data;
  end
  wire unused_fwd = ^{bus.i_exmem_regwrite, bus.i_exmem_rd, bus.i_exmem_result,
                      bus.i_memwb_regwrite, bus.i_memwb_rd, bus.i_memwb_result};
`endif

  assign bus.o_datoA      = stage_q.a_from_rt  ? rt_val      : rs_val;
  assign bus.o_datoB      = stage_q.b_from_imm ? stage_q.imm : rt_val;
  assign bus.o_alu_opcode = stage_q.alu_op;
  assign bus.o_valid      = stage_q.valid;
  assign bus.o_regwrite   = stage_q.regwrite;
  assign bus.o_wb_rd      = stage_q.wb_rd;
  assign bus.o_illegal    = stage_q.illegal;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: directed cases with literal expectations, then random traffic.
// A behavioural model (latched instruction record + decode table) is compared every negedge.
// Works with ID_EX_FORWARD_EN either defined or not.
module tb_id_ex_operand_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  id_ex_operand_stage_if bus ();

  id_ex_operand_stage dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

`ifdef ID_EX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit          bubble;
    logic [5:0]  op, funct;
    logic [4:0]  shamt, rs, rt, rd;
    logic [15:0] imm;
    logic [31:0] rs_data, rt_data;
  } rec_t;

  rec_t rec;

  // Returns {supported, operand kind[1:0], alu code[5:0]}.
  // kind 0: A=rs B=rt, 1: A=rt B=shamt, 2: A=rs B=sext(imm), 3: A=rs B=zext(imm)
  function automatic logic [8:0] decode(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) begin
      case (fn)
        6'h24: return {1'b1, 2'd0, 6'd0};
        6'h25: return {1'b1, 2'd0, 6'd1};
        6'h20: return {1'b1, 2'd0, 6'd2};
        6'h21: return {1'b1, 2'd0, 6'd3};
        6'h27: return {1'b1, 2'd0, 6'd4};
        6'h26: return {1'b1, 2'd0, 6'd5};
        6'h00: return {1'b1, 2'd1, 6'd6};
        6'h02: return {1'b1, 2'd1, 6'd7};
        6'h03: return {1'b1, 2'd1, 6'd8};
        6'h04: return {1'b1, 2'd0, 6'd9};
        6'h06: return {1'b1, 2'd0, 6'd10};
        6'h07: return {1'b1, 2'd0, 6'd11};
        6'h23: return {1'b1, 2'd0, 6'd12};
        6'h22: return {1'b1, 2'd0, 6'd13};
        6'h2A: return {1'b1, 2'd0, 6'd14};
        default: return 9'd0;
      endcase
    end
    case (op)
      6'h08: return {1'b1, 2'd2, 6'd2};
      6'h0A: return {1'b1, 2'd2, 6'd14};
      6'h0C: return {1'b1, 2'd3, 6'd0};
      6'h0D: return {1'b1, 2'd3, 6'd1};
      6'h0E: return {1'b1, 2'd3, 6'd5};
      6'h0F: return {1'b1, 2'd3, 6'd15};
      6'h23: return {1'b1, 2'd2, 6'd3};
      6'h2B: return {1'b1, 2'd2, 6'd3};
      default: return 9'd0;
    endcase
  endfunction

  function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] d,
                                      input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                                      input logic mw, input logic [4:0] mrd, input logic [31:0] mres);
    if (FWD && a != 0 && ew && erd == a) return eres;
    if (FWD && a != 0 && mw && mrd == a) return mres;
    return d;
  endfunction

  logic [31:0] exp_a, exp_b, rsv, rtv;
  logic [5:0]  exp_opc;
  logic [4:0]  exp_wb;
  logic        exp_v, exp_rw, exp_ill;
  logic [8:0]  dcd;

  always_comb begin
    exp_a = '0; exp_b = '0; exp_opc = '0; exp_wb = '0;
    exp_v = 1'b0; exp_rw = 1'b0; exp_ill = 1'b0;
    dcd = decode(rec.op, rec.funct);
    rsv = fwd(rec.rs, rec.rs_data, bus.i_exmem_regwrite, bus.i_exmem_rd, bus.i_exmem_result,
              bus.i_memwb_regwrite, bus.i_memwb_rd, bus.i_memwb_result);
    rtv = fwd(rec.rt, rec.rt_data, bus.i_exmem_regwrite, bus.i_exmem_rd, bus.i_exmem_result,
              bus.i_memwb_regwrite, bus.i_memwb_rd, bus.i_memwb_result);
    if (!rec.bubble) begin
      if (!dcd[8]) begin
        exp_ill = 1'b1;
      end else begin
        exp_v   = 1'b1;
        exp_opc = dcd[5:0];
        case (dcd[7:6])
          2'd0: begin exp_a = rsv; exp_b = rtv; end
          2'd1: begin exp_a = rtv; exp_b = {27'd0, rec.shamt}; end
          2'd2: begin exp_a = rsv; exp_b = {{16{rec.imm[15]}}, rec.imm}; end
          default: begin exp_a = rsv; exp_b = {16'd0, rec.imm}; end
        endcase
        exp_wb = (rec.op == 6'h00) ? rec.rd : rec.rt;
        exp_rw = (rec.op != 6'h2B) && (exp_wb != 5'd0);
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || bus.i_flush) begin
      rec.bubble <= 1'b1;
    end else if (!bus.i_stall) begin
      rec.bubble  <= !bus.i_valid;
      rec.op      <= bus.i_op;
      rec.funct   <= bus.i_funct;
      rec.shamt   <= bus.i_shamt;
      rec.imm     <= bus.i_imm;
      rec.rs      <= bus.i_rs_addr;
      rec.rt      <= bus.i_rt_addr;
      rec.rd      <= bus.i_rd_addr;
      rec.rs_data <= bus.i_rs_data;
      rec.rt_data <= bus.i_rt_data;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("m_datoA",  bus.o_datoA, exp_a);
    chk("m_datoB",  bus.o_datoB, exp_b);
    chk("m_opcode", {26'd0, bus.o_alu_opcode}, {26'd0, exp_opc});
    chk("m_valid",  {31'd0, bus.o_valid}, {31'd0, exp_v});
    chk("m_regwr",  {31'd0, bus.o_regwrite}, {31'd0, exp_rw});
    chk("m_wb_rd",  {27'd0, bus.o_wb_rd}, {27'd0, exp_wb});
    chk("m_illeg",  {31'd0, bus.o_illegal}, {31'd0, exp_ill});
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [5:0] op, input logic [5:0] fn,
                           input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic [4:0] sh, input logic [15:0] imm,
                           input logic [31:0] rsd, input logic [31:0] rtd);
    bus.i_valid = 1'b1; bus.i_op = op; bus.i_funct = fn;
    bus.i_rs_addr = rs; bus.i_rt_addr = rt; bus.i_rd_addr = rd;
    bus.i_shamt = sh; bus.i_imm = imm; bus.i_rs_data = rsd; bus.i_rt_data = rtd;
  endtask

  task automatic set_fwd(input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                         input logic mw, input logic [4:0] mrd, input logic [31:0] mres);
    bus.i_exmem_regwrite = ew; bus.i_exmem_rd = erd; bus.i_exmem_result = eres;
    bus.i_memwb_regwrite = mw; bus.i_memwb_rd = mrd; bus.i_memwb_result = mres;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_A"},   bus.o_datoA, 32'h0);
    chk({tag, "_B"},   bus.o_datoB, 32'h0);
    chk({tag, "_opc"}, {26'd0, bus.o_alu_opcode}, 32'h0);
    chk({tag, "_v"},   {31'd0, bus.o_valid}, 32'h0);
    chk({tag, "_rw"},  {31'd0, bus.o_regwrite}, 32'h0);
    chk({tag, "_wb"},  {27'd0, bus.o_wb_rd}, 32'h0);
    chk({tag, "_ill"}, {31'd0, bus.o_illegal}, 32'h0);
  endtask

  // Random legal-or-not instruction picker.
  function automatic logic [11:0] pick_opfn(input int k);
    case (k)
      0: return {6'h00, 6'h24};  1: return {6'h00, 6'h25};  2: return {6'h00, 6'h20};
      3: return {6'h00, 6'h21};  4: return {6'h00, 6'h27};  5: return {6'h00, 6'h26};
      6: return {6'h00, 6'h00};  7: return {6'h00, 6'h02};  8: return {6'h00, 6'h03};
      9: return {6'h00, 6'h04}; 10: return {6'h00, 6'h06}; 11: return {6'h00, 6'h07};
     12: return {6'h00, 6'h23}; 13: return {6'h00, 6'h22}; 14: return {6'h00, 6'h2A};
     15: return {6'h08, 6'($urandom)}; 16: return {6'h0A, 6'($urandom)};
     17: return {6'h0C, 6'($urandom)}; 18: return {6'h0D, 6'($urandom)};
     19: return {6'h0E, 6'($urandom)}; 20: return {6'h0F, 6'($urandom)};
     21: return {6'h23, 6'($urandom)}; 22: return {6'h2B, 6'($urandom)};
     default: return 12'($urandom);
    endcase
  endfunction

  initial begin
    set_instr(6'h00, 6'h20, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 32'h0, 32'h0);
    bus.i_valid = 1'b0; bus.i_stall = 1'b0; bus.i_flush = 1'b0;
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Reset state
    #1 rst_n = 1'b0;
    #2 chk_all_zero("reset");
    step();
    rst_n = 1'b1;

    // ADDI rs=1 (5), imm=FFFF
    set_instr(6'h08, 6'h00, 5'd1, 5'd7, 5'd0, 5'd0, 16'hFFFF, 32'h5, 32'h99);
    step();
    chk("addi_A",   bus.o_datoA, 32'h5);
    chk("addi_B",   bus.o_datoB, 32'hFFFF_FFFF);
    chk("addi_opc", {26'd0, bus.o_alu_opcode}, 32'h2);
    chk("addi_wb",  {27'd0, bus.o_wb_rd}, 32'd7);
    chk("addi_rw",  {31'd0, bus.o_regwrite}, 32'd1);
    chk("addi_v",   {31'd0, bus.o_valid}, 32'd1);

    // SLL rt=2 (1), shamt=4, then the same with rd=0
    set_instr(6'h00, 6'h00, 5'd6, 5'd2, 5'd9, 5'd4, 16'h0104, 32'h77, 32'h1);
    step();
    chk("sll_A",   bus.o_datoA, 32'h1);
    chk("sll_B",   bus.o_datoB, 32'h4);
    chk("sll_opc", {26'd0, bus.o_alu_opcode}, 32'h6);
    chk("sll_rw",  {31'd0, bus.o_regwrite}, 32'd1);
    bus.i_rd_addr = 5'd0;
    step();
    chk("nop_rw", {31'd0, bus.o_regwrite}, 32'd0);
    chk("nop_v",  {31'd0, bus.o_valid}, 32'd1);
    chk("nop_B",  bus.o_datoB, 32'h4);

    // Forwarding priority on rs=3
    set_instr(6'h00, 6'h20, 5'd3, 5'd4, 5'd8, 5'd0, 16'h0, 32'h11, 32'h44);
    set_fwd(1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB);
    step();
    chk("fwd_both_A", bus.o_datoA, FWD ? 32'hAA : 32'h11);
    chk("fwd_both_B", bus.o_datoB, 32'h44);
    bus.i_exmem_rd = 5'd0;
    #1;
    chk("fwd_memwb_A", bus.o_datoA, FWD ? 32'hBB : 32'h11);
    set_instr(6'h00, 6'h20, 5'd0, 5'd0, 5'd8, 5'd0, 16'h0, 32'h22, 32'h33);
    set_fwd(1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hBB);
    step();
    chk("fwd_r0_A", bus.o_datoA, 32'h22);
    chk("fwd_r0_B", bus.o_datoB, 32'h33);
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Stall holds for two cycles, then flush+stall gives a bubble
    set_instr(6'h00, 6'h20, 5'd5, 5'd6, 5'd10, 5'd0, 16'h0, 32'h10, 32'h20);
    step();
    set_instr(6'h00, 6'h26, 5'd1, 5'd2, 5'd11, 5'd0, 16'h0, 32'hDEAD, 32'hBEEF);
    bus.i_stall = 1'b1;
    step();
    step();
    chk("stall_A",   bus.o_datoA, 32'h10);
    chk("stall_B",   bus.o_datoB, 32'h20);
    chk("stall_opc", {26'd0, bus.o_alu_opcode}, 32'h2);
    chk("stall_wb",  {27'd0, bus.o_wb_rd}, 32'd10);
    bus.i_flush = 1'b1;
    step();
    chk_all_zero("flush");
    bus.i_flush = 1'b0; bus.i_stall = 1'b0;

    // Illegal op, then a valid ADD clears it
    set_instr(6'h3F, 6'h20, 5'd1, 5'd2, 5'd3, 5'd0, 16'h1234, 32'h1, 32'h2);
    step();
    chk("ill_flag", {31'd0, bus.o_illegal}, 32'd1);
    chk("ill_v",    {31'd0, bus.o_valid}, 32'd0);
    chk("ill_rw",   {31'd0, bus.o_regwrite}, 32'd0);
    set_instr(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 32'h1, 32'h2);
    step();
    chk("ill_clr", {31'd0, bus.o_illegal}, 32'd0);
    chk("ill_add_v", {31'd0, bus.o_valid}, 32'd1);

    // Asynchronous reset mid-stream
    set_instr(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 32'h5, 32'h6);
    step();
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    step();
    rst_n = 1'b1;

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [11:0] of;
      of = pick_opfn(int'($urandom_range(0, 25)));
      set_instr(of[11:6], of[5:0], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 5'($urandom), 16'($urandom), $urandom, $urandom);
      bus.i_valid = ($urandom_range(0, 7) != 0);
      bus.i_stall = ($urandom_range(0, 7) == 0);
      bus.i_flush = ($urandom_range(0, 15) == 0);
      set_fwd(1'($urandom), 5'($urandom_range(0, 3)), $urandom,
              1'($urandom), 5'($urandom_range(0, 3)), $urandom);
      step();
    end

    bus.i_stall = 1'b0; bus.i_flush = 1'b0; bus.i_valid = 1'b0;
    step();
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register and operand-select stage directly upstream of the EX-stage ALU in the 5-stage MIPS pipeline.
- Latches decoded instruction fields from ID, translates opcode/funct into the 6-bit ALU operation code, and selects ALU operands (register, immediate, shamt, forwarded data).
- Drives the ALU's A operand, B operand and operation code, plus write-back control for EX/MEM.

Parameters:
- N_BITS, 32, datapath width.
- N_OPCODE, 6, ALU operation code width.
- N_REG, 5, register address width.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_valid  in  1  ID holds a real instruction.
- i_op  in  6  instruction bits [31:26].
- i_funct  in  6  instruction bits [5:0].
- i_shamt  in  5  instruction bits [10:6].
- i_imm  in  16  instruction bits [15:0].
- i_rs_addr, i_rt_addr, i_rd_addr  in  N_REG  register addresses.
- i_rs_data, i_rt_data  in  N_BITS  register-file read data.
- i_stall  in  1  hold the stage.
- i_flush  in  1  load a bubble.
- i_exmem_regwrite  in  1  EX/MEM writes back.
- i_exmem_rd  in  N_REG  EX/MEM destination.
- i_exmem_result  in  N_BITS  EX/MEM result.
- i_memwb_regwrite  in  1  MEM/WB writes back.
- i_memwb_rd  in  N_REG  MEM/WB destination.
- i_memwb_result  in  N_BITS  MEM/WB result.
- o_datoA, o_datoB  out  N_BITS  ALU operands.
- o_alu_opcode  out  N_OPCODE  ALU operation code.
- o_valid  out  1  EX holds a real instruction.
- o_regwrite  out  1  instruction writes a register.
- o_wb_rd  out  N_REG  write-back register.
- o_illegal  out  1  unsupported op/funct was latched.

Behaviour:
- Reset (async, i_rst_n=0): every register clears. o_valid=0, o_regwrite=0, o_wb_rd=0, o_alu_opcode=000000, o_illegal=0, o_datoA=0, o_datoB=0.
- Latency: 1 cycle from ID inputs to outputs.
- Forwarding is combinational, applied to the latched rs/rt values using the current-cycle EX/MEM and MEM/WB inputs.
- Each rising edge, in priority order:
  - flush: load a bubble (all fields as at reset).
  - else stall: hold all registers.
  - else if i_valid=0: load a bubble.
  - else: capture the decode.
- Flush beats stall when both are asserted. During a stall, forwarding keeps re-evaluating.
- Decode for R-type (op=000000); funct → ALU code, A operand, B operand:
  - 100100 AND→000000, 100101 OR→000001, 100000 ADD→000010, 100001 ADDU→000011, 100111 NOR→000100, 100110 XOR→000101, 100011 SUBU→001100, 100010 SUB→001101, 101010 SLT→001110: A=rs, B=rt.
  - 000000 SLL→000110, 000010 SRL→000111, 000011 SRA→001000: A=rt, B=zero-extended shamt.
  - 000100 SLLV→001001, 000110 SRLV→001010, 000111 SRAV→001011: A=rs, B=rt.
  - wb_rd=rd.
- Decode for I-type (wb_rd=rt):
  - 001000 ADDI→ADD, 001010 SLTI→SLT: B=sign-extended imm.
  - 001100 ANDI→AND, 001101 ORI→OR, 001110 XORI→XOR: B=zero-extended imm.
  - 001111 LUI→LUI: B=zero-extended imm.
  - 100011 LW→ADDU: B=sign-extended imm. regwrite=1.
  - 101011 SW→ADDU: B=sign-extended imm. regwrite=0.
  - A=rs for all.
- Unsupported op/funct: latch as a bubble with o_illegal=1. o_illegal clears on the next capture, bubble or flush.
- SLL with rd=0 (NOP) decodes normally; regwrite is forced to 0 whenever wb_rd=0.
- Forwarding per source register (rs, rt):
  - EX/MEM if i_exmem_regwrite=1 and i_exmem_rd equals the source and is nonzero.
  - else MEM/WB under the same condition.
  - else the latched register data.
  - EX/MEM wins when both match.
  - The immediate and shamt operand slots are never forwarded.

Optional Feature:
- Macro ID_EX_FORWARD_EN.
- Defined: forwarding as above.
- Undefined: operands always use latched register data; forwarding inputs are ignored and must not affect outputs.

Test Plan:
- Reset mid-stream: drive ADD, assert i_rst_n=0 between edges → all outputs 0 immediately, without waiting for a clock edge.
- ADDI rs=1 (data 5), imm=FFFF, no forwarding → next cycle A=5, B=FFFFFFFF, opcode=000010, wb_rd=rt, regwrite=1.
- SLL rt=2 (data 1), shamt=4 → A=1, B=4, opcode=000110. Same encoding with rd=0 → regwrite=0.
- rs=3 with EX/MEM (rd=3, result=AA) and MEM/WB (rd=3, result=BB) both matching → A=AA. Set exmem_rd=0 → A=BB. Any match on register 0 → no forwarding.
- Stall for 2 cycles with new ID inputs → outputs hold. Flush together with stall → bubble on the next edge.
- op=111111 → o_illegal=1, o_valid=0, regwrite=0. Next capture of a valid ADD → o_illegal=0.
